// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state encoding and bus widths shared by the memory arbiter
package mem_arb_pkg;
  localparam int ADR_W = 20;
  localparam int DAT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic [DAT_W-1:0] TO_DATA = 16'hFFFF;
endpackage

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - round-robin arbiter of CPU (m0) and DMA/video (m1) onto one memory slave
// Optional MEM_ARB_TIMEOUT_EN: force-complete a grant after TO_CYCLES cycles without slave ack.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int TO_CYCLES = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m0_we_i,
  input  logic             m0_stb_i,
  input  logic             m0_byte_i,
  output logic             m0_ack_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  input  logic             m1_we_i,
  input  logic             m1_stb_i,
  input  logic             m1_byte_i,
  output logic             m1_ack_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic             s_we_o,
  output logic             s_stb_o,
  output logic             s_byte_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic             to_flag_o
);
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;
  logic       last_nxt;
  logic       gnt0;
  logic       gnt1;
  logic       gnt_stb;
  logic       to_hit;

  assign gnt0    = (state == ST_GNT0);
  assign gnt1    = (state == ST_GNT1);
  assign gnt_stb = gnt1 ? m1_stb_i : m0_stb_i;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_flag;

  // Counter sits at zero in IDLE, so every grant starts its budget fresh.
  assign to_hit = (gnt0 || gnt1) && (to_cnt == 8'(TO_CYCLES));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (!(gnt0 || gnt1)) begin
        to_cnt <= '0;
      end else if (!s_ack_i && !to_hit) begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (to_hit) begin
        to_flag <= 1'b1;
      end
    end
  end

  assign to_flag_o = to_flag;
`else
  logic unused_to_cycles;

  assign unused_to_cycles = ^TO_CYCLES;
  assign to_hit           = 1'b0;
  assign to_flag_o        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          state_nxt = last ? ST_GNT0 : ST_GNT1;
        end else if (m0_stb_i) begin
          state_nxt = ST_GNT0;
        end else if (m1_stb_i) begin
          state_nxt = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        // A completed transfer moves the round-robin pointer; an abort does not.
        if (s_ack_i || to_hit) begin
          state_nxt = ST_IDLE;
          last_nxt  = gnt1;
        end else if (!gnt_stb) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  assign s_adr_o  = gnt1 ? m1_adr_i  : m0_adr_i;
  assign s_dat_o  = gnt1 ? m1_dat_i  : m0_dat_i;
  assign s_byte_o = gnt1 ? m1_byte_i : m0_byte_i;
  assign s_we_o   = (gnt0 && m0_we_i) || (gnt1 && m1_we_i);
  assign s_stb_o  = ((gnt0 && m0_stb_i) || (gnt1 && m1_stb_i)) && !to_hit;

  assign m0_ack_o = gnt0 && (s_ack_i || to_hit);
  assign m1_ack_o = gnt1 && (s_ack_i || to_hit);
  assign m0_dat_o = to_hit ? TO_DATA : s_dat_i;
  assign m1_dat_o = to_hit ? TO_DATA : s_dat_i;
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb (timeout scenario with MEM_ARB_TIMEOUT_EN)
module tb_mem_arb;
  logic        clk_i;
  logic        rst_i;
  logic [19:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [15:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_we_i, m0_stb_i, m0_byte_i, m0_ack_o;
  logic        m1_we_i, m1_stb_i, m1_byte_i, m1_ack_o;
  logic        s_we_o, s_stb_o, s_byte_o, s_ack_i, to_flag_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  mem_arb #(.TO_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_byte_i(m0_byte_i), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_byte_i(m1_byte_i), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_byte_o(s_byte_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .to_flag_o(to_flag_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_stb_i = 0; m0_byte_i = 0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_stb_i = 0; m1_byte_i = 0;
    s_dat_i = '0; s_ack_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 0;
    tick();
    tick();
    rst_i = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 0;
    m0_stb_i = 1; m1_stb_i = 1; s_ack_i = 1;
    tick();
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_stb_o !== 1'b0) $display("FAIL rst_stb got %b exp 0", s_stb_o); else pass_cnt++;
    chk_cnt++; if (m0_ack_o !== 1'b0) $display("FAIL rst_ack0 got %b exp 0", m0_ack_o); else pass_cnt++;
    chk_cnt++; if (m1_ack_o !== 1'b0) $display("FAIL rst_ack1 got %b exp 0", m1_ack_o); else pass_cnt++;
    chk_cnt++; if (to_flag_o !== 1'b0) $display("FAIL rst_flag got %b exp 0", to_flag_o); else pass_cnt++;
    clear_inputs();
    tick();
    rst_i = 1;
  endtask

  task automatic test_single_read();
    logic [15:0] d;
    do_reset();
    m0_adr_i = 20'h00100; m0_we_i = 0; m0_stb_i = 1;
    @(negedge clk_i);
    chk_cnt++; if (s_stb_o !== 1'b0) $display("FAIL rd_latency got %b exp 0", s_stb_o); else pass_cnt++;
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_stb_o !== 1'b1) $display("FAIL rd_stb got %b exp 1", s_stb_o); else pass_cnt++;
    chk_cnt++; if (s_adr_o !== 20'h00100) $display("FAIL rd_adr got %h exp 00100", s_adr_o); else pass_cnt++;
    chk_cnt++; if (s_we_o !== 1'b0) $display("FAIL rd_we got %b exp 0", s_we_o); else pass_cnt++;
    chk_cnt++; if (m0_ack_o !== 1'b0) $display("FAIL rd_early_ack got %b exp 0", m0_ack_o); else pass_cnt++;
    tick();
    d = 16'($urandom);
    s_ack_i = 1; s_dat_i = d;
    @(negedge clk_i);
    chk_cnt++; if (m0_ack_o !== 1'b1) $display("FAIL rd_ack got %b exp 1", m0_ack_o); else pass_cnt++;
    chk_cnt++; if (m0_dat_o !== d) $display("FAIL rd_data got %h exp %h", m0_dat_o, d); else pass_cnt++;
    chk_cnt++; if (m1_ack_o !== 1'b0) $display("FAIL rd_other_ack got %b exp 0", m1_ack_o); else pass_cnt++;
    tick();
    m0_stb_i = 0; s_ack_i = 0;
    @(negedge clk_i);
    chk_cnt++; if (s_stb_o !== 1'b0) $display("FAIL rd_idle_stb got %b exp 0", s_stb_o); else pass_cnt++;
    chk_cnt++; if (m0_ack_o !== 1'b0) $display("FAIL rd_single_ack got %b exp 0", m0_ack_o); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_m;
    do_reset();
    m0_adr_i = 20'h0AAAA; m1_adr_i = 20'h05555;
    m0_stb_i = 1; m1_stb_i = 1; s_ack_i = 1;
    for (int k = 0; k < 4; k++) begin
      exp_m = k % 2;
      @(negedge clk_i);
      chk_cnt++; if (s_stb_o !== 1'b0) $display("FAIL rr_gap%0d got %b exp 0", k, s_stb_o); else pass_cnt++;
      tick();
      @(negedge clk_i);
      chk_cnt++; if (m0_ack_o !== 1'(exp_m == 0)) $display("FAIL rr_ack0_%0d got %b exp %b", k, m0_ack_o, exp_m == 0); else pass_cnt++;
      chk_cnt++; if (m1_ack_o !== 1'(exp_m == 1)) $display("FAIL rr_ack1_%0d got %b exp %b", k, m1_ack_o, exp_m == 1); else pass_cnt++;
      chk_cnt++; if (s_adr_o !== (exp_m == 1 ? 20'h05555 : 20'h0AAAA)) $display("FAIL rr_adr%0d got %h", k, s_adr_o); else pass_cnt++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_misaligned_write();
    logic [15:0] d;
    int acks;
    acks = 0;
    d = 16'($urandom);
    m1_adr_i = 20'h20001; m1_dat_i = d; m1_we_i = 1; m1_byte_i = 0; m1_stb_i = 1; s_ack_i = 0;
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_stb_o !== 1'b1) $display("FAIL wr_stb1 got %b exp 1", s_stb_o); else pass_cnt++;
    chk_cnt++; if (s_adr_o !== 20'h20001) $display("FAIL wr_adr got %h exp 20001", s_adr_o); else pass_cnt++;
    chk_cnt++; if (s_dat_o !== d) $display("FAIL wr_dat got %h exp %h", s_dat_o, d); else pass_cnt++;
    chk_cnt++; if ({s_we_o, s_byte_o} !== 2'b10) $display("FAIL wr_we_byte got %b exp 10", {s_we_o, s_byte_o}); else pass_cnt++;
    acks += int'(m1_ack_o);
    tick();
    s_ack_i = 1;
    @(negedge clk_i);
    chk_cnt++; if (s_stb_o !== 1'b1) $display("FAIL wr_stb2 got %b exp 1", s_stb_o); else pass_cnt++;
    acks += int'(m1_ack_o);
    tick();
    s_ack_i = 0; m1_stb_i = 0;
    @(negedge clk_i);
    acks += int'(m1_ack_o);
    chk_cnt++; if (s_stb_o !== 1'b0) $display("FAIL wr_stb3 got %b exp 0", s_stb_o); else pass_cnt++;
    chk_cnt++; if (acks !== 1) $display("FAIL wr_ack_count got %0d exp 1", acks); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    m0_adr_i = 20'h00111; m0_stb_i = 1;
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_stb_o !== 1'b1) $display("FAIL ab_stb got %b exp 1", s_stb_o); else pass_cnt++;
    m0_stb_i = 0; m1_adr_i = 20'h00222; m1_stb_i = 1;
    #1;
    chk_cnt++; if (s_stb_o !== 1'b0) $display("FAIL ab_drop got %b exp 0", s_stb_o); else pass_cnt++;
    tick();
    @(negedge clk_i);
    chk_cnt++; if ({s_stb_o, m0_ack_o, m1_ack_o} !== 3'b000) $display("FAIL ab_idle got %b exp 000", {s_stb_o, m0_ack_o, m1_ack_o}); else pass_cnt++;
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_adr_o !== 20'h00222 || s_stb_o !== 1'b1) $display("FAIL ab_m1_gnt got %h/%b exp 00222/1", s_adr_o, s_stb_o); else pass_cnt++;
    s_ack_i = 1;
    tick();
    clear_inputs();
    // m0 completes so the pointer favours m1, then an aborted m1 grant must leave it there
    m0_adr_i = 20'h00333; m0_stb_i = 1;
    tick();
    s_ack_i = 1;
    tick();
    s_ack_i = 0; m0_stb_i = 0; m1_adr_i = 20'h00444; m1_stb_i = 1;
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_adr_o !== 20'h00444) $display("FAIL ab2_gnt got %h exp 00444", s_adr_o); else pass_cnt++;
    m1_stb_i = 0;
    tick();
    m0_stb_i = 1; m1_stb_i = 1;
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_adr_o !== 20'h00444) $display("FAIL ab2_last_kept got %h exp 00444", s_adr_o); else pass_cnt++;
    s_ack_i = 1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    m1_adr_i = 20'h00555; m1_stb_i = 1;
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_stb_o !== 1'b1) $display("FAIL rm_stb got %b exp 1", s_stb_o); else pass_cnt++;
    rst_i = 0;
    #1;
    chk_cnt++; if (s_stb_o !== 1'b0) $display("FAIL rm_async_stb got %b exp 0", s_stb_o); else pass_cnt++;
    s_ack_i = 1;
    #1;
    chk_cnt++; if ({m0_ack_o, m1_ack_o} !== 2'b00) $display("FAIL rm_ack got %b exp 00", {m0_ack_o, m1_ack_o}); else pass_cnt++;
    tick();
    rst_i = 1; s_ack_i = 0;
    m0_adr_i = 20'h00666; m0_stb_i = 1;
    tick();
    @(negedge clk_i);
    chk_cnt++; if (s_adr_o !== 20'h00666 || s_stb_o !== 1'b1) $display("FAIL rm_last got %h/%b exp 00666/1", s_adr_o, s_stb_o); else pass_cnt++;
    s_ack_i = 1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random(input int ncyc);
    int owner, lastv, wl;
    logic r0, r1, ackd;
    logic [15:0] sd;
    logic [19:0] radr [2];
    logic [15:0] rdat [2];
    logic rwe [2];
    logic rbyte [2];
    logic pend [2];
    do_reset();
    owner = -1; lastv = 1; wl = 0; r0 = 0; r1 = 0; ackd = 0; sd = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; radr[m] = '0; rdat[m] = '0; rwe[m] = 0; rbyte[m] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_i);
      if (owner < 0) begin
        if (r0 && r1) owner = (lastv == 1) ? 0 : 1;
        else if (r0) owner = 0;
        else if (r1) owner = 1;
        wl = $urandom_range(0, 2);
      end else if (ackd) begin
        lastv = owner;
        pend[owner] = 0;
        owner = -1;
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1; radr[m] = 20'($urandom); rdat[m] = 16'($urandom);
          rwe[m] = 1'($urandom); rbyte[m] = 1'($urandom);
        end
      end
      m0_stb_i = pend[0]; m0_adr_i = radr[0]; m0_dat_i = rdat[0]; m0_we_i = rwe[0]; m0_byte_i = rbyte[0];
      m1_stb_i = pend[1]; m1_adr_i = radr[1]; m1_dat_i = rdat[1]; m1_we_i = rwe[1]; m1_byte_i = rbyte[1];
      ackd = 0;
      if (owner >= 0) begin
        if (wl == 0) ackd = 1;
        else wl--;
      end
      sd = 16'($urandom);
      s_ack_i = ackd; s_dat_i = sd;
      r0 = pend[0]; r1 = pend[1];
      @(negedge clk_i);
      chk_cnt++; if (s_stb_o !== 1'(owner >= 0)) $display("FAIL rnd_stb c%0d got %b owner %0d", c, s_stb_o, owner); else pass_cnt++;
      if (owner >= 0) begin
        chk_cnt++;
        if ({s_adr_o, s_dat_o, s_we_o, s_byte_o} !== {radr[owner], rdat[owner], rwe[owner], rbyte[owner]})
          $display("FAIL rnd_fwd c%0d got %h/%h/%b/%b exp %h/%h/%b/%b", c, s_adr_o, s_dat_o, s_we_o, s_byte_o,
                   radr[owner], rdat[owner], rwe[owner], rbyte[owner]);
        else pass_cnt++;
      end else begin
        chk_cnt++; if (s_we_o !== 1'b0) $display("FAIL rnd_idle_we c%0d got %b exp 0", c, s_we_o); else pass_cnt++;
      end
      chk_cnt++; if (m0_ack_o !== 1'(owner == 0 && ackd)) $display("FAIL rnd_ack0 c%0d got %b", c, m0_ack_o); else pass_cnt++;
      chk_cnt++; if (m1_ack_o !== 1'(owner == 1 && ackd)) $display("FAIL rnd_ack1 c%0d got %b", c, m1_ack_o); else pass_cnt++;
      chk_cnt++; if (m0_dat_o !== sd || m1_dat_o !== sd) $display("FAIL rnd_rdat c%0d got %h/%h exp %h", c, m0_dat_o, m1_dat_o, sd); else pass_cnt++;
      chk_cnt++; if (to_flag_o !== 1'b0) $display("FAIL rnd_flag c%0d got %b exp 0", c, to_flag_o); else pass_cnt++;
    end
    clear_inputs();
    tick();
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_adr_i = 20'h00777; m0_stb_i = 1; s_ack_i = 0; s_dat_i = 16'h1234;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk_cnt++; if ({s_stb_o, m0_ack_o} !== 2'b10) $display("FAIL to_wait%0d got %b exp 10", i, {s_stb_o, m0_ack_o}); else pass_cnt++;
      tick();
    end
    @(negedge clk_i);
    chk_cnt++; if (m0_ack_o !== 1'b1) $display("FAIL to_ack got %b exp 1", m0_ack_o); else pass_cnt++;
    chk_cnt++; if (m0_dat_o !== 16'hFFFF) $display("FAIL to_data got %h exp ffff", m0_dat_o); else pass_cnt++;
    chk_cnt++; if ({s_stb_o, m1_ack_o} !== 2'b00) $display("FAIL to_stb got %b exp 00", {s_stb_o, m1_ack_o}); else pass_cnt++;
    tick();
    m0_stb_i = 0;
    @(negedge clk_i);
    chk_cnt++; if (to_flag_o !== 1'b1) $display("FAIL to_flag got %b exp 1", to_flag_o); else pass_cnt++;
    chk_cnt++; if (m0_ack_o !== 1'b0) $display("FAIL to_pulse got %b exp 0", m0_ack_o); else pass_cnt++;
    m0_stb_i = 1; m1_stb_i = 1; m1_adr_i = 20'h00888;
    tick();
    s_ack_i = 1;
    @(negedge clk_i);
    chk_cnt++; if ({m0_ack_o, m1_ack_o} !== 2'b01) $display("FAIL to_last got %b exp 01", {m0_ack_o, m1_ack_o}); else pass_cnt++;
    tick();
    clear_inputs();
    tick();
    @(negedge clk_i);
    chk_cnt++; if (to_flag_o !== 1'b1) $display("FAIL to_sticky got %b exp 1", to_flag_o); else pass_cnt++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst_i = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_misaligned_write();
    test_abort();
    test_reset_mid_grant();
    test_random(400);
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: TO_CYCLES, default 15, timeout limit in clk_i cycles (1..255); only used when MEM_ARB_TIMEOUT_EN is defined.
REQ-002 clk_i  in  1  single clock; all state is updated on the rising edge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 mN_adr_i  in  20  master N address (N=0 CPU, N=1 DMA/video), one port per master.
REQ-005 mN_dat_i  in  16  master N write data.
REQ-006 mN_dat_o  out  16  master N read data.
REQ-007 mN_we_i / mN_stb_i / mN_byte_i  in  1 each  master N write enable, strobe, byte access.
REQ-008 mN_ack_o  out  1  master N acknowledge.
REQ-009 s_adr_o  out  20; s_dat_o  out  16; s_we_o, s_stb_o, s_byte_o  out  1 each: slave port to the SRAM/flash memory controller.
REQ-010 s_dat_i  in  16; s_ack_i  in  1: slave read data and acknowledge.
REQ-011 to_flag_o  out  1  sticky timeout indication (tied 0 without the macro).

Function
REQ-012 The FSM SHALL have states IDLE, GNT0 and GNT1, with a registered 1-bit last-granted pointer `last`.
REQ-013 IDLE, one request: the FSM SHALL move to the requester's GNT state next cycle.
REQ-014 IDLE, both requests: the FSM SHALL grant the master that is not `last` (round-robin).
REQ-015 In GNTn, s_adr_o/s_dat_o/s_we_o/s_byte_o SHALL be driven from master n combinationally.
REQ-016 s_stb_o SHALL equal (state==GNTn) && mn_stb_i.
REQ-017 In IDLE, s_stb_o and s_we_o SHALL be 0 and all other slave outputs SHALL be don't-care, driven from master 0.
REQ-018 mn_ack_o SHALL equal (state==GNTn) && s_ack_i; a non-granted master's ack SHALL be 0.
REQ-019 Both mN_dat_o SHALL carry s_dat_i unconditionally.
REQ-020 On s_ack_i in GNTn, the FSM SHALL return to IDLE and set last<=n.
REQ-021 Arbitration latency SHALL be exactly 1 cycle from stb to s_stb_o; each transfer is followed by one IDLE cycle.
REQ-022 If mn_stb_i drops while in GNTn without ack (abort), the FSM SHALL return to IDLE with `last` unchanged.
REQ-023 A master SHALL NOT be granted while its stb is low; the grant SHALL hold until ack or abort, never preempted.
REQ-024 Misaligned words SHALL pass through unchanged, since the slave splits them; the grant SHALL stay held across the slave's two-cycle access.

Reset
REQ-025 While rst_i=0: state=IDLE, last=1 (so master 0 wins the first tie), timeout counter=0, to_flag_o=0.
REQ-026 While rst_i=0, all ack and s_stb_o outputs SHALL be 0.
REQ-027 Reset asserted mid-grant SHALL abandon the transfer immediately with no ack.

Configuration
REQ-028 With MEM_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering GNTn and increment each GNT cycle without s_ack_i.
REQ-029 When the counter reaches TO_CYCLES, mn_ack_o SHALL pulse 1 cycle with mN_dat_o=16'hFFFF, s_stb_o SHALL drop, the FSM SHALL go to IDLE with last<=n, and to_flag_o SHALL set until reset.
REQ-030 Without the macro, no counter logic SHALL exist, a grant SHALL wait indefinitely for ack, and to_flag_o SHALL be 0.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the address/data widths (20/16).
REQ-032 The design SHALL be a single flat module; the round-robin pick is simple enough that it SHALL NOT be a separate sub-module.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- m0 read adr 20'h00100, slave acks 1 cycle after s_stb_o: m0_ack_o one cycle, m0_dat_o=s_dat_i, m1_ack_o=0.
- m0 and m1 stb together from reset: m0 granted first, m1 next; repeated simultaneous requests alternate 0,1,0,1.
- m1 word write at odd adr 20'h20001, slave holds ack off 1 cycle: s_stb_o held 2 cycles, single m1_ack_o.
- m0 drops stb during GNT0 before ack: IDLE next cycle, no ack, m1 then granted.
- rst_i low during GNT1: s_stb_o=0 asynchronously, state IDLE, last=1.
- With MEM_ARB_TIMEOUT_EN, TO_CYCLES=4, slave never acks: m0_ack_o after 4 grant cycles, m0_dat_o=16'hFFFF, to_flag_o=1 and sticky.
